// File: rtl/openram_scan_ctrl.sv
// Scan-chain front end for the OpenRAM testchip: a serial packet drives one registered
// dual-port SRAM access per global_csb strobe, and the read data is folded back into the packet.
module openram_scan_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int WMASK_W   = 4,
  parameter int NUM_BANKS = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        scan_en,
  input  logic                        scan_in,
  output logic                        scan_out,
  input  logic                        sram_load,
  input  logic                        global_csb,
  output logic [NUM_BANKS-1:0]        csb0_o,
  output logic [NUM_BANKS-1:0]        csb1_o,
  output logic                        web0_o,
  output logic                        web1_o,
  output logic [ADDR_W-1:0]           addr0_o,
  output logic [ADDR_W-1:0]           addr1_o,
  output logic [DATA_W-1:0]           din0_o,
  output logic [DATA_W-1:0]           din1_o,
  output logic [WMASK_W-1:0]          wmask0_o,
  output logic [WMASK_W-1:0]          wmask1_o,
  input  logic [NUM_BANKS*DATA_W-1:0] dout0_i,
  input  logic [NUM_BANKS*DATA_W-1:0] dout1_i,
  output logic                        busy_o
);

  localparam int SEL_W  = 4;
  localparam int PORT_W = ADDR_W + DATA_W + 2 + WMASK_W;
  localparam int PKT_W  = SEL_W + 2 * PORT_W;

  // Port 1 occupies the low half of the packet, port 0 sits directly above it.
  localparam int WM1_LSB   = 0;
  localparam int WEB1_BIT  = WMASK_W;
  localparam int CSB1_BIT  = WMASK_W + 1;
  localparam int DIN1_LSB  = WMASK_W + 2;
  localparam int ADDR1_LSB = DIN1_LSB + DATA_W;
  localparam int WM0_LSB   = WM1_LSB + PORT_W;
  localparam int WEB0_BIT  = WEB1_BIT + PORT_W;
  localparam int CSB0_BIT  = CSB1_BIT + PORT_W;
  localparam int DIN0_LSB  = DIN1_LSB + PORT_W;
  localparam int ADDR0_LSB = ADDR1_LSB + PORT_W;
  localparam int SEL_LSB   = 2 * PORT_W;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    CAPTURE,
    READY
  } state_e;

  state_e               state_q, state_d;
  logic [PKT_W-1:0]     pkt_q, pkt_d;
  logic                 armed_q, armed_d;
  logic [SEL_W-1:0]     accSel_q, accSel_d;
  logic                 accRd0_q, accRd0_d;
  logic                 accRd1_q, accRd1_d;
  logic [DATA_W-1:0]    rdata0_q, rdata0_d;
  logic [DATA_W-1:0]    rdata1_q, rdata1_d;
  logic [NUM_BANKS-1:0] csb0_q, csb0_d;
  logic [NUM_BANKS-1:0] csb1_q, csb1_d;
  logic                 web0_q, web0_d;
  logic                 web1_q, web1_d;
  logic [ADDR_W-1:0]    addr0_q, addr0_d;
  logic [ADDR_W-1:0]    addr1_q, addr1_d;
  logic [DATA_W-1:0]    din0_q, din0_d;
  logic [DATA_W-1:0]    din1_q, din1_d;
  logic [WMASK_W-1:0]   wmask0_q, wmask0_d;
  logic [WMASK_W-1:0]   wmask1_q, wmask1_d;

  logic [SEL_W-1:0]     pktSel;
  logic [NUM_BANKS-1:0] bankCsb0, bankCsb1;
  logic [DATA_W-1:0]    bankRd0, bankRd1;
  logic                 startAccess;

  assign pktSel = pkt_q[SEL_LSB +: SEL_W];

  // Chip-select decode from the packet and read-data mux from the latched bank; an
  // out-of-range select matches no bank, so selects stay high and the data reads as zero.
  always_comb begin
    bankCsb0 = '1;
    bankCsb1 = '1;
    bankRd0  = '0;
    bankRd1  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (pktSel == SEL_W'(b)) begin
        bankCsb0[b] = pkt_q[CSB0_BIT];
        bankCsb1[b] = pkt_q[CSB1_BIT];
      end
      if (accSel_q == SEL_W'(b)) begin
        bankRd0 = dout0_i[b*DATA_W +: DATA_W];
        bankRd1 = dout1_i[b*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pkt_q    <= '0;
      armed_q  <= 1'b0;
      accSel_q <= '0;
      accRd0_q <= 1'b0;
      accRd1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      csb0_q   <= '1;
      csb1_q   <= '1;
      web0_q   <= 1'b1;
      web1_q   <= 1'b1;
      addr0_q  <= '0;
      addr1_q  <= '0;
      din0_q   <= '0;
      din1_q   <= '0;
      wmask0_q <= '0;
      wmask1_q <= '0;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      armed_q  <= armed_d;
      accSel_q <= accSel_d;
      accRd0_q <= accRd0_d;
      accRd1_q <= accRd1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      csb0_q   <= csb0_d;
      csb1_q   <= csb1_d;
      web0_q   <= web0_d;
      web1_q   <= web1_d;
      addr0_q  <= addr0_d;
      addr1_q  <= addr1_d;
      din0_q   <= din0_d;
      din1_q   <= din1_d;
      wmask0_q <= wmask0_d;
      wmask1_q <= wmask1_d;
    end
  end

  // armed_q records that global_csb has been seen high while idle or ready, so a strobe
  // held low across a whole access cannot launch a second one.
  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    armed_d     = armed_q;
    accSel_d    = accSel_q;
    accRd0_d    = accRd0_q;
    accRd1_d    = accRd1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    csb0_d      = csb0_q;
    csb1_d      = csb1_q;
    web0_d      = web0_q;
    web1_d      = web1_q;
    addr0_d     = addr0_q;
    addr1_d     = addr1_q;
    din0_d      = din0_q;
    din1_d      = din1_q;
    wmask0_d    = wmask0_q;
    wmask1_d    = wmask1_q;
    startAccess = 1'b0;

    if (scan_en) begin
      pkt_d = {pkt_q[PKT_W-2:0], scan_in};
    end

    case (state_q)
      IDLE: begin
        if (global_csb) begin
          armed_d = 1'b1;
        end else if (!scan_en && armed_q) begin
          startAccess = 1'b1;
        end
      end
      ACCESS: begin
        csb0_d  = '1;
        csb1_d  = '1;
        state_d = WAIT;
      end
      WAIT: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rdata0_d = bankRd0;
        rdata1_d = bankRd1;
        state_d  = READY;
      end
      READY: begin
        if (global_csb) begin
          armed_d = 1'b1;
        end
        if (!scan_en && sram_load) begin
          if (accRd0_q) pkt_d[DIN0_LSB +: DATA_W] = rdata0_q;
          if (accRd1_q) pkt_d[DIN1_LSB +: DATA_W] = rdata1_q;
          state_d = IDLE;
        end else if (!scan_en && !global_csb && armed_q) begin
          startAccess = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (startAccess) begin
      state_d  = ACCESS;
      armed_d  = 1'b0;
      accSel_d = pktSel;
      accRd0_d = ~pkt_q[CSB0_BIT] & pkt_q[WEB0_BIT];
      accRd1_d = ~pkt_q[CSB1_BIT] & pkt_q[WEB1_BIT];
      csb0_d   = bankCsb0;
      csb1_d   = bankCsb1;
      web0_d   = pkt_q[WEB0_BIT];
      web1_d   = pkt_q[WEB1_BIT];
      addr0_d  = pkt_q[ADDR0_LSB +: ADDR_W];
      addr1_d  = pkt_q[ADDR1_LSB +: ADDR_W];
      din0_d   = pkt_q[DIN0_LSB +: DATA_W];
      din1_d   = pkt_q[DIN1_LSB +: DATA_W];
      wmask0_d = pkt_q[WM0_LSB +: WMASK_W];
      wmask1_d = pkt_q[WM1_LSB +: WMASK_W];
    end
  end

  assign scan_out = pkt_q[PKT_W-1];
  assign busy_o   = (state_q == ACCESS) || (state_q == WAIT) || (state_q == CAPTURE);
  assign csb0_o   = csb0_q;
  assign csb1_o   = csb1_q;
  assign web0_o   = web0_q;
  assign web1_o   = web1_q;
  assign addr0_o  = addr0_q;
  assign addr1_o  = addr1_q;
  assign din0_o   = din0_q;
  assign din1_o   = din1_q;
  assign wmask0_o = wmask0_q;
  assign wmask1_o = wmask1_q;

endmodule

// File: tb/tb_openram_scan_ctrl.sv
// Bench for openram_scan_ctrl: a 16-bank and an 8-bank instance share one stimulus stream
// and are both compared every cycle against a packet/age-counter model of the scan controller.
module tb_openram_scan_ctrl;

   // Two instances let the out-of-range bank select be exercised with 4-bit sel.
   logic clk = 1'b0;
   logic reset_n, scanEn, scanIn, sramLoad, globalCsb;
   logic [16*32-1:0] dout0, dout1;

   logic scanOutA, scanOutB, busyA, busyB;
   logic [15:0] csb0A, csb1A;
   logic [7:0] csb0B, csb1B;
   logic web0A, web1A, web0B, web1B;
   logic [15:0] addr0A, addr1A, addr0B, addr1B;
   logic [31:0] din0A, din1A, din0B, din1B;
   logic [3:0] wmask0A, wmask1A, wmask0B, wmask1B;

   int errors = 0;
   int checks = 0;
   bit cmpEn = 1'b0;

   openram_scan_ctrl #(.NUM_BANKS(16)) dutA (
      .clk(clk), .reset_n(reset_n), .scan_en(scanEn), .scan_in(scanIn), .scan_out(scanOutA),
      .sram_load(sramLoad), .global_csb(globalCsb), .csb0_o(csb0A), .csb1_o(csb1A),
      .web0_o(web0A), .web1_o(web1A), .addr0_o(addr0A), .addr1_o(addr1A),
      .din0_o(din0A), .din1_o(din1A), .wmask0_o(wmask0A), .wmask1_o(wmask1A),
      .dout0_i(dout0), .dout1_i(dout1), .busy_o(busyA)
   );

   openram_scan_ctrl #(.NUM_BANKS(8)) dutB (
      .clk(clk), .reset_n(reset_n), .scan_en(scanEn), .scan_in(scanIn), .scan_out(scanOutB),
      .sram_load(sramLoad), .global_csb(globalCsb), .csb0_o(csb0B), .csb1_o(csb1B),
      .web0_o(web0B), .web1_o(web1B), .addr0_o(addr0B), .addr1_o(addr1B),
      .din0_o(din0B), .din1_o(din1B), .wmask0_o(wmask0B), .wmask1_o(wmask1B),
      .dout0_i(dout0[8*32-1:0]), .dout1_i(dout1[8*32-1:0]), .busy_o(busyB)
   );

   // Free-running clock, first rising edge at 5.
   always #5 clk = ~clk;

   // Model state per instance; mAge counts cycles since the strobe (0 idle, 1..3 busy, 4 ready).
   logic [111:0] mPkt [2];
   int mAge [2];
   bit mArmed [2];
   logic [3:0] mSel [2];
   bit mRd0 [2], mRd1 [2];
   logic [31:0] mCap0 [2], mCap1 [2];
   logic [15:0] mCsb0 [2], mCsb1 [2];
   logic mWeb0 [2], mWeb1 [2];
   logic [15:0] mAddr0 [2], mAddr1 [2];
   logic [31:0] mDin0 [2], mDin1 [2];
   logic [3:0] mWm0 [2], mWm1 [2];

   function automatic int nbOf(input int m);
      return (m == 0) ? 16 : 8;
   endfunction

   function automatic logic [31:0] bankWord(input logic [511:0] v, input logic [3:0] sel, input int nb);
      if (int'(sel) < nb) return v[int'(sel)*32 +: 32];
      return 32'h0;
   endfunction

   function automatic logic [111:0] makePkt(
      input logic [3:0] sel, input logic [15:0] a0, input logic [31:0] d0, input logic c0, input logic w0,
      input logic [3:0] m0, input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1,
      input logic [3:0] m1);
      return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
   endfunction

   task automatic modelReset();
      for (int m = 0; m < 2; m++) begin
         mPkt[m] = '0; mAge[m] = 0; mArmed[m] = 1'b0; mSel[m] = '0; mRd0[m] = 1'b0; mRd1[m] = 1'b0;
         mCap0[m] = '0; mCap1[m] = '0; mCsb0[m] = '1; mCsb1[m] = '1; mWeb0[m] = 1'b1; mWeb1[m] = 1'b1;
         mAddr0[m] = '0; mAddr1[m] = '0; mDin0[m] = '0; mDin1[m] = '0; mWm0[m] = '0; mWm1[m] = '0;
      end
   endtask

   task automatic modelStep();
      bit start;
      int age;
      logic [3:0] sel;
      if (!reset_n) begin
         modelReset();
         return;
      end
      for (int m = 0; m < 2; m++) begin
         age = mAge[m];
         start = !scanEn && !globalCsb && mArmed[m] && (age == 0 || (age == 4 && !sramLoad));
         if (age == 1) begin
            mCsb0[m] = '1;
            mCsb1[m] = '1;
         end
         if (age == 3) begin
            mCap0[m] = bankWord(dout0, mSel[m], nbOf(m));
            mCap1[m] = bankWord(dout1, mSel[m], nbOf(m));
         end
         if (start) begin
            sel = mPkt[m][111:108];
            mSel[m] = sel;
            mRd0[m] = !mPkt[m][59] && mPkt[m][58];
            mRd1[m] = !mPkt[m][5] && mPkt[m][4];
            mCsb0[m] = '1;
            mCsb1[m] = '1;
            if (int'(sel) < nbOf(m) && !mPkt[m][59]) mCsb0[m][sel] = 1'b0;
            if (int'(sel) < nbOf(m) && !mPkt[m][5]) mCsb1[m][sel] = 1'b0;
            mWeb0[m] = mPkt[m][58];  mWeb1[m] = mPkt[m][4];
            mAddr0[m] = mPkt[m][107:92];  mAddr1[m] = mPkt[m][53:38];
            mDin0[m] = mPkt[m][91:60];  mDin1[m] = mPkt[m][37:6];
            mWm0[m] = mPkt[m][57:54];  mWm1[m] = mPkt[m][3:0];
         end
         if (age == 0 || age == 4) begin
            if (start) mArmed[m] = 1'b0;
            else if (globalCsb) mArmed[m] = 1'b1;
         end
         if (scanEn) begin
            mPkt[m] = {mPkt[m][110:0], scanIn};
         end else if (age == 4 && sramLoad) begin
            if (mRd0[m]) mPkt[m][91:60] = mCap0[m];
            if (mRd1[m]) mPkt[m][37:6] = mCap1[m];
         end
         if (start) mAge[m] = 1;
         else if (age >= 1 && age <= 3) mAge[m] = age + 1;
         else if (age == 4 && !scanEn && sramLoad) mAge[m] = 0;
      end
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Drives one cycle of inputs, lets the edge happen, advances the model and settles 1 ns later.
   task automatic applyStimulus(input logic se, input logic si, input logic ld, input logic gc);
      scanEn = se; scanIn = si; sramLoad = ld; globalCsb = gc;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic shiftPacket(input logic [111:0] p);
      for (int i = 111; i >= 0; i--) applyStimulus(1'b1, p[i], 1'b0, 1'b1);
   endtask

   task automatic readPacket(output logic [111:0] gotA, output logic [111:0] gotB);
      for (int i = 111; i >= 0; i--) begin
         gotA[i] = scanOutA;
         gotB[i] = scanOutB;
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      end
   endtask

   // Every negative edge both instances are compared against the model.
   always @(negedge clk) begin
      if (cmpEn) begin
         for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("scan_out[%0d]", m), (m == 0) ? scanOutA : scanOutB, mPkt[m][111]);
            checkOutput($sformatf("busy[%0d]", m), (m == 0) ? busyA : busyB, (mAge[m] >= 1 && mAge[m] <= 3));
            checkOutput($sformatf("csb0[%0d]", m), (m == 0) ? csb0A : {8'hFF, csb0B}, mCsb0[m]);
            checkOutput($sformatf("csb1[%0d]", m), (m == 0) ? csb1A : {8'hFF, csb1B}, mCsb1[m]);
            checkOutput($sformatf("web0[%0d]", m), (m == 0) ? web0A : web0B, mWeb0[m]);
            checkOutput($sformatf("web1[%0d]", m), (m == 0) ? web1A : web1B, mWeb1[m]);
            checkOutput($sformatf("addr0[%0d]", m), (m == 0) ? addr0A : addr0B, mAddr0[m]);
            checkOutput($sformatf("addr1[%0d]", m), (m == 0) ? addr1A : addr1B, mAddr1[m]);
            checkOutput($sformatf("din0[%0d]", m), (m == 0) ? din0A : din0B, mDin0[m]);
            checkOutput($sformatf("din1[%0d]", m), (m == 0) ? din1A : din1B, mDin1[m]);
            checkOutput($sformatf("wmask0[%0d]", m), (m == 0) ? wmask0A : wmask0B, mWm0[m]);
            checkOutput($sformatf("wmask1[%0d]", m), (m == 0) ? wmask1A : wmask1B, mWm1[m]);
         end
      end
   end

   initial begin
      logic [111:0] pkt, expA, expB, gotA, gotB;
      int busyCnt, csbCnt;
      logic se, ld, gc;

      scanEn = 1'b0; scanIn = 1'b0; sramLoad = 1'b0; globalCsb = 1'b1;
      dout0 = '0; dout1 = '0;
      reset_n = 1'b1;
      #1;
      reset_n = 1'b0;
      modelReset();
      cmpEn = 1'b1;
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      reset_n = 1'b1;

      $display("[TB] reset state");
      checkOutput("rst_scan_out", scanOutA, 1'b0);
      checkOutput("rst_busy", busyA, 1'b0);
      checkOutput("rst_csb0", csb0A, 16'hFFFF);
      checkOutput("rst_web0", web0A, 1'b1);

      $display("[TB] write access on bank 2");
      pkt = makePkt(4'd2, 16'd1, 32'h2, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF);
      shiftPacket(pkt);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_csb0", csb0A, 16'hFFFB);
      checkOutput("t1_csb0_b", csb0B, 8'hFB);
      checkOutput("t1_addr0", addr0A, 16'd1);
      checkOutput("t1_din0", din0A, 32'd2);
      checkOutput("t1_web0", web0A, 1'b0);
      checkOutput("t1_csb1", csb1A, 16'hFFFF);
      checkOutput("t1_model_csb0", mCsb0[0], 16'hFFFB);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("t1_csb0_release", csb0A, 16'hFFFF);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] dual-port read on bank 3");
      dout0[3*32 +: 32] = 32'hDEADBEEF;
      dout1[3*32 +: 32] = 32'h00000018;
      pkt = makePkt(4'd3, 16'h0010, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0020, 32'h0, 1'b0, 1'b1, 4'hF);
      shiftPacket(pkt);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      readPacket(gotA, gotB);
      expA = makePkt(4'd3, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF, 16'h0020, 32'h00000018, 1'b0, 1'b1, 4'hF);
      checkOutput("t2_scan_a", gotA, expA);
      checkOutput("t2_scan_b", gotB, expA);

      $display("[TB] port 0 read only on bank 5");
      dout0[5*32 +: 32] = 32'hA5A50F0F;
      dout1[5*32 +: 32] = 32'hFFFFFFFF;
      pkt = makePkt(4'd5, 16'h0007, 32'h0, 1'b0, 1'b1, 4'h1, 16'h0009, 32'h12345678, 1'b1, 1'b1, 4'h2);
      shiftPacket(pkt);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      readPacket(gotA, gotB);
      expA = makePkt(4'd5, 16'h0007, 32'hA5A50F0F, 1'b0, 1'b1, 4'h1, 16'h0009, 32'h12345678, 1'b1, 1'b1, 4'h2);
      checkOutput("t3_scan_a", gotA, expA);
      checkOutput("t3_scan_b", gotB, expA);

      $display("[TB] sel 15, out of range on the 8-bank instance");
      dout0[15*32 +: 32] = 32'h0BADF00D;
      pkt = makePkt(4'd15, 16'h0042, 32'h0, 1'b0, 1'b1, 4'h3, 16'h0043, 32'hCAFE0001, 1'b0, 1'b0, 4'h5);
      shiftPacket(pkt);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t4_csb0_b", csb0B, 8'hFF);
      checkOutput("t4_csb1_b", csb1B, 8'hFF);
      checkOutput("t4_csb0_a", csb0A, 16'h7FFF);
      checkOutput("t4_csb1_a", csb1A, 16'h7FFF);
      busyCnt = 0;
      for (int i = 0; i < 5; i++) begin
         busyCnt += int'(busyB);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      end
      checkOutput("t4_busy_cycles", busyCnt, 3);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      readPacket(gotA, gotB);
      expA = makePkt(4'd15, 16'h0042, 32'h0BADF00D, 1'b0, 1'b1, 4'h3, 16'h0043, 32'hCAFE0001, 1'b0, 1'b0, 4'h5);
      expB = pkt;
      checkOutput("t4_scan_a", gotA, expA);
      checkOutput("t4_scan_b", gotB, expB);

      $display("[TB] strobe held low while shifting");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0);
         checkOutput("t5_csb0_idle", csb0A, 16'hFFFF);
         checkOutput("t5_busy_idle", busyA, 1'b0);
      end
      pkt = makePkt(4'd1, 16'h0100, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0200, 32'h0, 1'b1, 1'b1, 4'hF);
      shiftPacket(pkt);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      busyCnt = 0;
      csbCnt = 0;
      for (int i = 0; i < 6; i++) begin
         busyCnt += int'(busyA);
         csbCnt += int'(csb0A != 16'hFFFF);
         applyStimulus(1'b0, 1'b0, 1'b0, (i == 0) ? 1'b0 : 1'b1);
      end
      checkOutput("t5_busy_cycles", busyCnt, 3);
      checkOutput("t5_csb_cycles", csbCnt, 1);

      $display("[TB] reset during access");
      pkt = makePkt(4'd2, 16'd1, 32'h2, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF);
      shiftPacket(pkt);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t6_csb0_active", csb0A, 16'hFFFB);
      #2;
      reset_n = 1'b0;
      modelReset();
      #1;
      checkOutput("t6_csb0_async", csb0A, 16'hFFFF);
      checkOutput("t6_csb0_b_async", csb0B, 8'hFF);
      checkOutput("t6_csb1_async", csb1A, 16'hFFFF);
      reset_n = 1'b1;
      checkOutput("t6_scan_out", scanOutA, 1'b0);
      checkOutput("t6_busy", busyA, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] random traffic");
      for (int c = 0; c < 2500; c++) begin
         for (int b = 0; b < 16; b++) begin
            dout0[b*32 +: 32] = $urandom;
            dout1[b*32 +: 32] = $urandom;
         end
         se = ($urandom_range(0, 99) < 40);
         ld = ($urandom_range(0, 99) < 15);
         gc = ($urandom_range(0, 99) >= 12);
         if (ld) gc = 1'b1;
         applyStimulus(se, 1'($urandom), ld, gc);
      end
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      cmpEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/openram_scan_ctrl.md
Name: openram_scan_ctrl

Overview:
- User-project front end for the OpenRAM testchip. Converts the GPIO scan interface into registered dual-port SRAM requests.
- Shifts in one 112-bit packet MSB-first, issues a single SRAM access when global_csb is pulsed low, and captures read data.
- Writes the read data back into the packet so it can be shifted out on the same chain.
- Sits between the mprj_io GPIO pads and the SRAM macro bank array.

Parameters:
- ADDR_W, 16, address width per port
- DATA_W, 32, data width per port
- WMASK_W, 4, write-mask width per port
- NUM_BANKS, 16, number of SRAM macros selectable by sel

Ports:
- clk  in  1  scan/SRAM clock (gpio_clk pad)
- reset_n  in  1  asynchronous active-low reset
- scan_en  in  1  shift enable
- scan_in  in  1  serial data in
- scan_out  out  1  serial data out, equal to pkt[111]
- sram_load  in  1  load captured read data into the packet
- global_csb  in  1  active-low access strobe
- csb0_o, csb1_o  out  NUM_BANKS each  per-bank active-low chip selects
- web0_o, web1_o  out  1  write enable, active low
- addr0_o, addr1_o  out  ADDR_W  address
- din0_o, din1_o  out  DATA_W  write data
- wmask0_o, wmask1_o  out  WMASK_W  write mask
- dout0_i, dout1_i  in  NUM_BANKS*DATA_W  flattened read data; bank b occupies bits [b*DATA_W +: DATA_W]
- busy_o  out  1  access or capture in flight

Behaviour:
- Packet register pkt[111:0], fields MSB to LSB: sel[3:0], addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1.
- All outputs and registers are cleared asynchronously on reset_n=0, with these exceptions:
  - csb0_o and csb1_o reset to all ones.
  - web0_o and web1_o reset to 1.
  - The FSM resets to IDLE.
- Shift: when scan_en=1 at a clk edge, pkt <= {pkt[110:0], scan_in}. scan_out is combinational pkt[111], so the first bit is valid immediately after load or reset.
- Priority at each edge: scan_en, then sram_load, then global_csb.
  - If scan_en=1, global_csb=0 is ignored and the SRAM outputs stay idle.
  - If scan_en=1, sram_load is ignored.
- FSM states: IDLE, ACCESS, WAIT, CAPTURE, READY.
  - IDLE: if global_csb=0 and scan_en=0, register the SRAM outputs from pkt and go to ACCESS.
    - Bank b chip select is asserted (csbX_o[b]=0) only if sel==b and the packet csbX=0.
    - sel >= NUM_BANKS leaves all chip selects high, but the access sequence still runs.
    - sel, web0 and web1 are latched into access registers.
  - ACCESS: csb outputs are held for exactly one cycle (the macro samples at this edge). Then return all csb to 1 and go to WAIT.
  - WAIT: read data from the macro is valid. Go to CAPTURE.
  - CAPTURE: doutX_q <= dout slice selected by the latched sel (zero if out of range). Go to READY.
  - READY: on sram_load=1 and scan_en=0:
    - din0 field <= dout0_q if the latched port 0 access was a read (csb0=0 and web0=1); otherwise the field is unchanged.
    - The same rule applies to port 1.
    - Go to IDLE.
  - READY: on global_csb=0, start a new access (same action as IDLE) and discard the captured data.
- Read-data latency: global_csb low sampled at edge N gives chip select asserted during N to N+1, macro sample at N+1, capture at N+3, sram_load honoured from edge N+4.
- busy_o=1 in ACCESS, WAIT and CAPTURE.
- global_csb=0 while busy: ignored. A held-low global_csb does not retrigger until it is seen high in IDLE or READY.
- sram_load in IDLE: no effect.
- Write-only packets go through the same FSM. The load writes nothing back.
- Reset mid-access: csb outputs return high immediately (asynchronously) and the captured data is lost.

Test Plan:
- Reset, then shift 112 bits of {4'd2, 16'd1, 32'h00000002, 0,0, 4'hF, 16'd0, 32'd0, 1,1, 4'hF}, then pulse global_csb low for one cycle. Required: csb0_o=16'hFFFB for exactly one cycle, addr0_o=1, din0_o=2, web0_o=0, csb1_o=16'hFFFF.
- Read on bank 3 with dout0_i[3]=32'hDEADBEEF and dout1_i[3]=32'h00000018, both ports reading: strobe, wait 3 cycles, sram_load, scan out. Required: the serial stream equals the packet with din0=DEADBEEF and din1=00000018, bit-exact, no X.
- Read on port 0 only, with scanned din1=32'h12345678 and port 1 csb=1. Required: after load and scan-out, din1 is still 12345678.
- sel=4'd15 with NUM_BANKS=8. Required: all csb stay high, busy_o pulses for 3 cycles, loaded din0=0.
- Hold global_csb=0 while scan_en=1 for 10 cycles. Required: no chip select asserted and the FSM stays in IDLE. Pulse global_csb during ACCESS: no second access.
- Deassert reset_n in the ACCESS cycle. Required: csb outputs go high immediately, and after reset release scan_out=0 and busy_o=0.
